// File: rtl/ibex_instr_resp_pkg.sv
// Shared types and helpers for the instruction-fetch bus responder.
// Holds the queued response entry and the address window check.
package ibex_instr_resp_pkg;

  // Countdown field width; supports latencies up to 256 cycles.
  localparam int unsigned LatW = 8;

  typedef struct packed {
    logic [31:0]     data;
    logic            err;
    logic [LatW-1:0] cnt;
  } resp_entry_t;

  // Window check done in 33 bits so a window touching 4 GiB cannot wrap.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] words);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (words << 2);
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/ibex_instr_bus_responder_if.sv
// Instruction fetch bus (req/gnt/rvalid) between the core-side requester
// and the memory-side responder.
interface ibex_instr_bus_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ibex_instr_resp_checker.sv
// Protocol and queue-integrity properties for the instruction bus responder.
module ibex_instr_resp_checker #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntW           = 2
) (
  input logic            clk_int_stored,
  input logic            rst_ni,
  input logic            push_i,
  input logic            pop_i,
  input logic            full_i,
  input logic            empty_i,
  input logic [CntW-1:0] count_i,
  input logic            req_i,
  input logic            gnt_i,
  input logic [31:0]     addr_i
);

  a_no_overflow: assert property (@(posedge clk_int_stored) disable iff (!rst_ni)
    !(push_i && full_i && !pop_i));

  a_no_underflow: assert property (@(posedge clk_int_stored) disable iff (!rst_ni)
    !(pop_i && empty_i));

  a_count_bound: assert property (@(posedge clk_int_stored) disable iff (!rst_ni)
    count_i <= CntW'(MaxOutstanding));

  a_addr_stable: assert property (@(posedge clk_int_stored) disable iff (!rst_ni)
    (req_i && !gnt_i) |=> $stable(addr_i));

endmodule

// File: rtl/ibex_instr_resp_queue.sv
// In-order circular queue of granted responses; every queued entry counts
// down its own latency and the head is offered once its count reaches zero.
module ibex_instr_resp_queue
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_int_stored,
  input  logic            rst_ni,
  input  logic            push_i,
  input  resp_entry_t     push_entry_i,
  input  logic            pop_i,
  output logic            head_ready_o,
  output logic [31:0]     head_data_o,
  output logic            head_err_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  resp_entry_t     entries_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue storage, pointers, occupancy and per-entry countdown.
  always_ff @(posedge clk_int_stored or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        entries_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (valid_q[i] && (entries_q[i].cnt != '0)) begin
          entries_q[i].cnt <= entries_q[i].cnt - 1'b1;
        end
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      // Placed after the pop so a push into the slot being freed wins.
      if (push_i) begin
        entries_q[wr_ptr_q] <= push_entry_i;
        valid_q[wr_ptr_q]   <= 1'b1;
        wr_ptr_q            <= ptr_inc(wr_ptr_q);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign head_ready_o = valid_q[rd_ptr_q] && (entries_q[rd_ptr_q].cnt == '0);
  assign head_data_o  = entries_q[rd_ptr_q].data;
  assign head_err_o   = entries_q[rd_ptr_q].err;
  assign full_o       = (count_q == CntW'(Depth));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Memory-side responder for the instruction fetch bus: grants requests,
// snapshots the addressed word at grant and returns it in order.
module ibex_instr_bus_responder
  import ibex_instr_resp_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RespLatency    = 1
) (
  input  logic                      clk_int_stored,
  input  logic                      rst_ni,
  ibex_instr_bus_responder_if.slave instr_bus,
  input  logic                      gnt_stall_i,
  input  logic                      load_we_i,
  input  logic [31:0]               load_addr_i,
  input  logic [31:0]               load_wdata_i,
  output logic                      busy_o
);
  localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [31:0]     mem_q [MemWords];
  logic [IdxW-1:0] fetch_idx_s;
  logic [IdxW-1:0] load_idx_s;
  logic            fetch_err_s;
  logic            load_ok_s;
  logic            gnt_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [CntW-1:0] count_s;
  logic [31:0]     head_data_s;
  logic            head_err_s;
  resp_entry_t     push_entry_s;

  assign fetch_idx_s = IdxW'((instr_bus.addr - BaseAddr) >> 2'd2);
  assign load_idx_s  = IdxW'((load_addr_i - BaseAddr) >> 2'd2);
  assign fetch_err_s = ~in_range(instr_bus.addr, BaseAddr, 33'(MemWords));
  assign load_ok_s   = in_range(load_addr_i, BaseAddr, 33'(MemWords));

  // A full queue still accepts when the head leaves this cycle.
  assign gnt_s = rst_ni & instr_bus.req & ~gnt_stall_i & ~load_we_i & (~full_s | pop_s);

  // Response entry captured at grant; errored fetches carry zero data.
  always_comb begin
    push_entry_s.data = fetch_err_s ? 32'h0000_0000 : mem_q[fetch_idx_s];
    push_entry_s.err  = fetch_err_s;
    push_entry_s.cnt  = LatW'(RespLatency - 1);
  end

  // Backdoor loader; the array is intentionally not reset.
  always_ff @(posedge clk_int_stored) begin
    if (load_we_i && load_ok_s) begin
      mem_q[load_idx_s] <= load_wdata_i;
    end
  end

  ibex_instr_resp_queue #(
    .Depth (MaxOutstanding),
    .CntW  (CntW)
  ) u_queue (
    .clk_int_stored (clk_int_stored),
    .rst_ni         (rst_ni),
    .push_i         (gnt_s),
    .push_entry_i   (push_entry_s),
    .pop_i          (pop_s),
    .head_ready_o   (pop_s),
    .head_data_o    (head_data_s),
    .head_err_o     (head_err_s),
    .full_o         (full_s),
    .empty_o        (empty_s),
    .count_o        (count_s)
  );

  ibex_instr_resp_checker #(
    .MaxOutstanding (MaxOutstanding),
    .CntW           (CntW)
  ) u_checker (
    .clk_int_stored (clk_int_stored),
    .rst_ni         (rst_ni),
    .push_i         (gnt_s),
    .pop_i          (pop_s),
    .full_i         (full_s),
    .empty_i        (empty_s),
    .count_i        (count_s),
    .req_i          (instr_bus.req),
    .gnt_i          (gnt_s),
    .addr_i         (instr_bus.addr)
  );

  assign instr_bus.gnt    = gnt_s;
  assign instr_bus.rvalid = pop_s;
  assign instr_bus.rdata  = head_data_s;
  assign instr_bus.err    = head_err_s;
  assign busy_o           = ~empty_s;

endmodule
